// File: rtl/pipedcache.sv
// rtl/pipedcache.sv - direct-mapped write-through no-write-allocate data cache with MEM-stage stall
module pipedcache #(
    parameter int LINES = 16
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        mrmem,
    input  logic        mwmem,
    input  logic [31:0] maddr,
    input  logic [31:0] mdi,
    input  logic        imem_ready,
    output logic [31:0] mmo,
    output logic        mem_ready,
    output logic        m_req,
    output logic        m_we,
    output logic [31:0] m_addr,
    output logic [31:0] m_wdata,
    input  logic [31:0] m_rdata,
    input  logic        m_ack
);
    localparam int IW = $clog2(LINES);
    localparam int TW = 30 - IW;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RD,
        S_WR,
        S_DONE
    } state_t;

    state_t state_q, state_d;

    logic [LINES-1:0] valid_q;
    logic [TW-1:0]    tag_ram  [LINES];
    logic [31:0]      data_ram [LINES];
    logic [31:0]      hold_q;

    logic [IW-1:0] index;
    logic [TW-1:0] tag;
    logic          hit;

    // Fill and update use the latched memory address, so they never depend on the MEM-stage bus.
    logic [IW-1:0] w_index;
    logic [TW-1:0] w_tag;
    logic          w_hit;

    logic fill_en;
    logic upd_en;
    logic issue_rd;
    logic issue_wr;
    logic finish;
    logic unused_byte_bits;

    assign index   = maddr[IW+1:2];
    assign tag     = maddr[31:IW+2];
    assign hit     = valid_q[index] && (tag_ram[index] == tag);
    assign w_index = m_addr[IW+1:2];
    assign w_tag   = m_addr[31:IW+2];
    assign w_hit   = valid_q[w_index] && (tag_ram[w_index] == w_tag);

    assign unused_byte_bits = ^maddr[1:0];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        mem_ready = 1'b0;
        mmo       = 32'd0;
        fill_en   = 1'b0;
        upd_en    = 1'b0;
        issue_rd  = 1'b0;
        issue_wr  = 1'b0;
        finish    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (mwmem) begin
                    issue_wr = 1'b1;
                    state_d  = S_WR;
                end else if (mrmem) begin
                    if (hit) begin
                        mem_ready = 1'b1;
                        mmo       = data_ram[index];
                    end else begin
                        issue_rd = 1'b1;
                        state_d  = S_RD;
                    end
                end else begin
                    mem_ready = 1'b1;
                end
            end
            S_RD: begin
                if (m_ack) begin
                    mem_ready = 1'b1;
                    mmo       = m_rdata;
                    fill_en   = 1'b1;
                    finish    = 1'b1;
                    state_d   = imem_ready ? S_IDLE : S_DONE;
                end
            end
            S_WR: begin
                if (m_ack) begin
                    mem_ready = 1'b1;
                    upd_en    = w_hit;
                    finish    = 1'b1;
                    state_d   = imem_ready ? S_IDLE : S_DONE;
                end
            end
            S_DONE: begin
                mem_ready = 1'b1;
                mmo       = hold_q;
                if (imem_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        // Reset overrides everything so an abandoned transaction cannot fill or update a line.
        if (reset) begin
            mem_ready = 1'b0;
            mmo       = 32'd0;
            fill_en   = 1'b0;
            upd_en    = 1'b0;
            issue_rd  = 1'b0;
            issue_wr  = 1'b0;
            finish    = 1'b0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            m_req   <= 1'b0;
            m_we    <= 1'b0;
            m_addr  <= 32'd0;
            m_wdata <= 32'd0;
            hold_q  <= 32'd0;
            valid_q <= '0;
        end else begin
            if (issue_rd) begin
                m_req  <= 1'b1;
                m_we   <= 1'b0;
                m_addr <= {maddr[31:2], 2'b00};
            end
            if (issue_wr) begin
                m_req   <= 1'b1;
                m_we    <= 1'b1;
                m_addr  <= {maddr[31:2], 2'b00};
                m_wdata <= mdi;
            end
            if (finish) begin
                m_req <= 1'b0;
                m_we  <= 1'b0;
            end
            // DONE after a store must present 0, so the hold register is cleared on store completion.
            if (fill_en) begin
                hold_q           <= m_rdata;
                valid_q[w_index] <= 1'b1;
            end else if (finish) begin
                hold_q <= 32'd0;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (fill_en) begin
            tag_ram[w_index]  <= w_tag;
            data_ram[w_index] <= m_rdata;
        end else if (upd_en) begin
            data_ram[w_index] <= m_wdata;
        end
    end

endmodule

// File: tb/tb_pipedcache.sv
// tb/tb_pipedcache.sv - directed scoreboard bench for pipedcache
module tb_pipedcache;
    logic        clock = 1'b0;
    logic        reset;
    logic        mrmem;
    logic        mwmem;
    logic [31:0] maddr;
    logic [31:0] mdi;
    logic        imem_ready;
    logic [31:0] mmo;
    logic        mem_ready;
    logic        m_req;
    logic        m_we;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic [31:0] m_rdata;
    logic        m_ack;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q[$];
    logic [31:0] mem_model[logic [31:0]];

    pipedcache #(.LINES(16)) dut (
        .clock      (clock),
        .reset      (reset),
        .mrmem      (mrmem),
        .mwmem      (mwmem),
        .maddr      (maddr),
        .mdi        (mdi),
        .imem_ready (imem_ready),
        .mmo        (mmo),
        .mem_ready  (mem_ready),
        .m_req      (m_req),
        .m_we       (m_we),
        .m_addr     (m_addr),
        .m_wdata    (m_wdata),
        .m_rdata    (m_rdata),
        .m_ack      (m_ack)
    );

    always #5 clock = ~clock;

    function automatic logic [31:0] mem_read(input logic [31:0] a);
        if (mem_model.exists(a)) return mem_model[a];
        return a ^ 32'h5A5A_0000;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One MEM-stage access; the memory acks after `delay` wait cycles of m_req.
    task automatic do_op(input string tag, input bit wr, input logic [31:0] a,
                         input logic [31:0] d, input int delay, input int exp_stall);
        int          stall = 0;
        int          reqc  = 0;
        bit          done  = 1'b0;
        logic [31:0] wa;
        logic [31:0] exp;
        wa = {a[31:2], 2'b00};
        @(posedge clock); #1;
        mrmem = !wr;
        mwmem = wr;
        maddr = a;
        mdi   = d;
        m_ack = 1'b0;
        if (!wr) exp_q.push_back(mem_read(wa));
        for (int cyc = 0; cyc < 100 && !done; cyc++) begin
            if (cyc > 0) begin
                @(posedge clock); #1;
                m_ack = 1'b0;
            end
            if (m_req) begin
                if (reqc == 0) begin
                    check({tag, " m_addr"}, m_addr, wa);
                    check({tag, " m_we"}, 32'(m_we), 32'(wr));
                    if (wr) check({tag, " m_wdata"}, m_wdata, d);
                end
                if (reqc == delay) begin
                    m_ack   = 1'b1;
                    m_rdata = mem_read(wa);
                    if (wr) mem_model[wa] = d;
                end
                reqc++;
            end
            @(negedge clock);
            if (mem_ready) begin
                done = 1'b1;
                if (!wr) begin
                    exp = exp_q.pop_front();
                    check({tag, " mmo"}, mmo, exp);
                end
            end else begin
                stall++;
            end
        end
        check({tag, " completed"}, 32'(done), 32'd1);
        check({tag, " stall"}, 32'(stall), 32'(exp_stall));
        check({tag, " req cycles"}, 32'(reqc), (exp_stall == 0) ? 32'd0 : 32'(delay + 1));
    endtask

    task automatic idle_step(input string tag);
        @(posedge clock); #1;
        mrmem = 1'b0;
        mwmem = 1'b0;
        m_ack = 1'b0;
        @(negedge clock);
        check({tag, " mem_ready"}, 32'(mem_ready), 32'd1);
        check({tag, " mmo"}, mmo, 32'd0);
    endtask

    initial begin
        reset      = 1'b0;
        mrmem      = 1'b0;
        mwmem      = 1'b0;
        maddr      = 32'd0;
        mdi        = 32'd0;
        imem_ready = 1'b1;
        m_rdata    = 32'd0;
        m_ack      = 1'b0;
        #2 reset = 1'b1;
        #1;
        check("reset m_req", 32'(m_req), 32'd0);
        check("reset m_we", 32'(m_we), 32'd0);
        check("reset m_addr", m_addr, 32'd0);
        check("reset m_wdata", m_wdata, 32'd0);
        check("reset mem_ready", 32'(mem_ready), 32'd0);
        check("reset mmo", mmo, 32'd0);
        @(negedge clock);
        @(negedge clock); #1;
        reset = 1'b0;

        idle_step("idle");
        mem_model[32'h40] = 32'h1234_5678;
        do_op("miss40", 1'b0, 32'h40, 32'd0, 3, 4);
        do_op("hit40", 1'b0, 32'h40, 32'd0, 0, 0);
        do_op("st40", 1'b1, 32'h40, 32'hDEAD_BEEF, 1, 2);
        do_op("hit40 after st", 1'b0, 32'h40, 32'd0, 0, 0);
        do_op("st80 uncached", 1'b1, 32'h80, 32'hCAFE_F00D, 0, 1);
        do_op("miss80 no alloc", 1'b0, 32'h80, 32'd0, 2, 3);
        do_op("miss40 evicted", 1'b0, 32'h43, 32'd0, 0, 1);

        // Completion while the instruction side stalls must park in DONE.
        idle_step("pre done");
        imem_ready = 1'b0;
        do_op("done load", 1'b0, 32'h2C, 32'd0, 1, 2);
        for (int i = 0; i < 2; i++) begin
            @(posedge clock); #1;
            m_ack = 1'b0;
            @(negedge clock);
            check("done m_req", 32'(m_req), 32'd0);
            check("done mem_ready", 32'(mem_ready), 32'd1);
            check("done mmo", mmo, mem_read(32'h2C));
        end
        @(posedge clock); #1;
        imem_ready = 1'b1;
        @(negedge clock);
        check("done exit mem_ready", 32'(mem_ready), 32'd1);
        check("done exit mmo", mmo, mem_read(32'h2C));
        idle_step("after done");
        do_op("hit2C", 1'b0, 32'h2C, 32'd0, 0, 0);

        // Reset in the middle of RD abandons the fill.
        @(posedge clock); #1;
        mrmem = 1'b1;
        mwmem = 1'b0;
        maddr = 32'h114;
        m_ack = 1'b0;
        @(negedge clock);
        check("rst miss mem_ready", 32'(mem_ready), 32'd0);
        @(posedge clock); #1;
        @(negedge clock);
        check("rst rd m_req", 32'(m_req), 32'd1);
        #1 reset = 1'b1;
        #1;
        check("rst async m_req", 32'(m_req), 32'd0);
        check("rst async mem_ready", 32'(mem_ready), 32'd0);
        check("rst async mmo", mmo, 32'd0);
        m_ack   = 1'b1;
        m_rdata = 32'hBAD0_BAD0;
        @(posedge clock); #1;
        m_ack = 1'b0;
        mrmem = 1'b0;
        @(negedge clock);
        check("rst held mem_ready", 32'(mem_ready), 32'd0);
        check("rst held m_req", 32'(m_req), 32'd0);
        #1 reset = 1'b0;
        #1;
        check("rst release mem_ready", 32'(mem_ready), 32'd1);
        do_op("miss114 after rst", 1'b0, 32'h114, 32'd0, 0, 1);
        do_op("hit114", 1'b0, 32'h114, 32'd0, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
